lsu_multi_outstanding: RTL and testbench
========================================

// Module: lsu_multi_outstanding
// PURPOSE
//  Load/store unit for the pipelined core's MEM stage. Supports up to DEPTH outstanding data-memory
//  transactions over the valid/yumi dmem handshake, replacing the single-transaction mem_stage counter.
//  Responses return in order and retire to writeback tagged with their destination register.
//  Sits between the X/M pipeline register and the M/W register.
// PARAMETERS
//  ADDR_W     32  data memory address width
//  DATA_W     32  load/store data width (>=8)
//  RD_W       5   destination register tag width
//  DEPTH      4   max outstanding transactions; power of two, >=2
//  BYTE_SEXT  0   1: byte loads sign-extended; 0: zero-extended
// PORTS
//  clk          in   1        clock; all state updates on posedge
//  reset        in   1        asynchronous, active-high reset
//  req_valid_i  in   1        core presents LD/ST request
//  req_ready_o  out  1        unit accepts request this cycle
//  req_wen_i    in   1        1 store, 0 load
//  req_byte_i   in   1        byte (1) / word (0) access
//  req_addr_i   in   ADDR_W   address
//  req_wdata_i  in   DATA_W   store data
//  req_rd_i     in   RD_W     load destination register
//  flush_i      in   1        drop not-yet-issued request
//  mem_valid_o  out  1        request to dmem
//  mem_wen_o / mem_byte_o / mem_addr_o / mem_wdata_o  out  1/1/ADDR_W/DATA_W  held request fields
//  mem_yumi_i   in   1        dmem accepted mem_* this cycle
//  mem_rvalid_i in   1        dmem response valid
//  mem_rdata_i  in   DATA_W   response data
//  mem_yumi_o   out  1        unit consumes response this cycle
//  wb_valid_o   out  1        retiring transaction
//  wb_ready_i   in   1        writeback can take it (0 = commit stall)
//  wb_is_load_o / wb_rd_o / wb_data_o  out  1/RD_W/DATA_W  retire info
//  count_o      out  $clog2(DEPTH+1)  tracked transactions
//  busy_o       out  1        count_o != 0
//  err_o        out  1        sticky protocol error
// BEHAVIOUR
//  Reset: pending=0, count=0, FIFO pointers 0, err_o=0; hence req_ready_o=1, mem_valid_o=0,
//   mem_yumi_o=0, wb_valid_o=0, busy_o=0. Reset mid-operation discards everything; stale dmem responses afterwards set err_o.
//  Accept: req_valid_i & req_ready_o. req_ready_o = !pending & (count<DEPTH), registered-state only (no comb path from mem_yumi_i).
//   On accept: request fields latched into pending holding register; {wen,byte,rd} pushed to tracking FIFO; count+1.
//  Issue: mem_valid_o = pending; mem_* driven from holding register, stable until mem_yumi_i. mem_yumi_i clears pending next edge.
//   Accepted request issued the following cycle (1-cycle latency).
//  Flush: flush_i & pending & !mem_yumi_i -> pending cleared, youngest FIFO entry popped, count-1.
//   flush_i with mem_yumi_i same cycle: acceptance wins, no flush. flush_i never affects issued transactions.
//   flush_i and new accept in same cycle: flush wins, req_ready_o forced 0.
//  Retire: mem_rvalid_i & count>0 & FIFO head issued -> wb_valid_o=1 combinationally with head fields.
//   wb_data_o: word load = mem_rdata_i; byte load = low byte extended per BYTE_SEXT; store = 0.
//   mem_yumi_o = wb_valid_o & wb_ready_i; on it FIFO pops head, count-1.
//  Count: simultaneous accept and retire -> unchanged; flush and retire same cycle -> count-2.
//  Error: mem_rvalid_i with no issued entry tracked -> mem_yumi_o=1 (drop), wb_valid_o=0, err_o set until reset.
//  FIFO: circular, pointers wrap modulo DEPTH; full at count==DEPTH blocks accept; no overflow/underflow possible.
//  Stores occupy a slot until their dmem response; in-order retire, no reordering.
// TESTING
//  1 Reset asserted mid-burst with 3 outstanding -> next cycle count_o=0, req_ready_o=1, mem_valid_o=0, err_o=0.
//  2 Four loads rd=1..4 back-to-back, mem_yumi_i=1 always, responses 10,20,30,40 -> wb rd/data 1/10..4/40 in order; count_o peaks 4, req_ready_o=0 at count 4.
//  3 Byte load, mem_rdata_i=0x000000F3: BYTE_SEXT=0 -> wb_data_o=0x000000F3; BYTE_SEXT=1 -> 0xFFFFFFF3.
//  4 Pending store, mem_yumi_i=0 for 5 cycles -> mem_* stable 5 cycles; flush_i on cycle 3 -> mem_valid_o=0 next cycle, count_o-1, no response expected.
//  5 mem_rvalid_i=1 with wb_ready_i=0 for 3 cycles -> mem_yumi_o=0, wb_valid_o=1 held; wb_ready_i=1 -> single retire, count-1.
//  6 mem_rvalid_i=1 while count_o=0 -> mem_yumi_o=1, wb_valid_o=0, err_o=1 persisting until reset.

Source files
------------

// File: rtl/lsu_multi_outstanding.sv
// Load/store unit for the MEM stage with up to DEPTH in-flight dmem transactions.
// Requests are latched into a single holding register and issued over the
// valid/yumi handshake; a tracking FIFO remembers {wen, byte, rd} per
// transaction so in-order responses retire to writeback with their tag.
// Ports:
//   clk, reset                    clock, async active-high reset
//   req_*  (valid/ready/wen/byte/addr/wdata/rd), flush_i   core request side
//   mem_*  (valid/wen/byte/addr/wdata out, yumi in)          dmem request side
//   mem_rvalid_i, mem_rdata_i, mem_yumi_o                   dmem response side
//   wb_*   (valid/is_load/rd/data out, ready in)            writeback side
//   count_o, busy_o, err_o                                  status
module lsu_multi_outstanding #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RD_W      = 5,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned BYTE_SEXT = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_wen_i,
    input  logic                         req_byte_i,
    input  logic [ADDR_W-1:0]            req_addr_i,
    input  logic [DATA_W-1:0]            req_wdata_i,
    input  logic [RD_W-1:0]              req_rd_i,
    input  logic                         flush_i,
    output logic                         mem_valid_o,
    output logic                         mem_wen_o,
    output logic                         mem_byte_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic [DATA_W-1:0]            mem_wdata_o,
    input  logic                         mem_yumi_i,
    input  logic                         mem_rvalid_i,
    input  logic [DATA_W-1:0]            mem_rdata_i,
    output logic                         mem_yumi_o,
    output logic                         wb_valid_o,
    input  logic                         wb_ready_i,
    output logic                         wb_is_load_o,
    output logic [RD_W-1:0]              wb_rd_o,
    output logic [DATA_W-1:0]            wb_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Holding register for the one not-yet-issued request
    logic                r_pending;
    logic                r_wen;
    logic                r_byte;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    // Tracking FIFO, one entry per outstanding transaction (pending included)
    logic                r_fifo_wen  [DEPTH];
    logic                r_fifo_byte [DEPTH];
    logic [RD_W-1:0]     r_fifo_rd   [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_err;

    logic                w_accept;
    logic                w_flush;
    logic                w_head_issued;
    logic                w_wb_valid;
    logic                w_retire;
    logic                w_drop;
    logic                w_head_wen;
    logic                w_head_byte;
    logic [DATA_W-1:0]   w_byte_ext;
    logic [DATA_W-1:0]   w_wb_data;
    logic [CNT_W-1:0]    w_count_nxt;

    // The pending entry is always the youngest, so the head is unissued only
    // when it is the sole tracked entry and still pending.
    always_comb begin
        w_head_issued = (r_count != '0) && !(r_pending && (r_count == CNT_W'(1)));
        req_ready_o   = !r_pending && (r_count < CNT_W'(DEPTH)) && !flush_i;
        w_accept      = req_valid_i && req_ready_o;
        w_flush       = flush_i && r_pending && !mem_yumi_i;
        w_wb_valid    = mem_rvalid_i && w_head_issued;
        w_retire      = w_wb_valid && wb_ready_i;
        w_drop        = mem_rvalid_i && !w_head_issued;
    end

    // Retire data formatting: stores return zero, byte loads extended
    always_comb begin
        w_head_wen  = r_fifo_wen[r_rd_ptr];
        w_head_byte = r_fifo_byte[r_rd_ptr];
        w_byte_ext  = DATA_W'(mem_rdata_i[7:0]);
        if ((BYTE_SEXT != 0) && mem_rdata_i[7]) begin
            w_byte_ext = w_byte_ext | ({DATA_W{1'b1}} << 8);
        end
        w_wb_data = mem_rdata_i;
        if (w_head_wen) begin
            w_wb_data = '0;
        end else if (w_head_byte) begin
            w_wb_data = w_byte_ext;
        end
    end

    // Occupancy: accept adds one, flush and retire each remove one
    always_comb begin
        w_count_nxt = r_count;
        if (w_accept) w_count_nxt = w_count_nxt + CNT_W'(1);
        if (w_flush)  w_count_nxt = w_count_nxt - CNT_W'(1);
        if (w_retire) w_count_nxt = w_count_nxt - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_wen     <= 1'b0;
            r_byte    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_fifo_wen[i]  <= 1'b0;
                r_fifo_byte[i] <= 1'b0;
                r_fifo_rd[i]   <= '0;
            end
        end else begin
            // accept requires !r_pending, so it never collides with yumi or flush
            if (w_accept) begin
                r_pending             <= 1'b1;
                r_wen                 <= req_wen_i;
                r_byte                <= req_byte_i;
                r_addr                <= req_addr_i;
                r_wdata               <= req_wdata_i;
                r_fifo_wen[r_wr_ptr]  <= req_wen_i;
                r_fifo_byte[r_wr_ptr] <= req_byte_i;
                r_fifo_rd[r_wr_ptr]   <= req_rd_i;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end else if (w_flush) begin
                r_pending <= 1'b0;
                r_wr_ptr  <= r_wr_ptr - PTR_W'(1);
            end else if (r_pending && mem_yumi_i) begin
                r_pending <= 1'b0;
            end
            if (w_retire) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_valid_o  = r_pending;
    assign mem_wen_o    = r_wen;
    assign mem_byte_o   = r_byte;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;
    assign mem_yumi_o   = w_retire || w_drop;
    assign wb_valid_o   = w_wb_valid;
    assign wb_is_load_o = !w_head_wen;
    assign wb_rd_o      = r_fifo_rd[r_rd_ptr];
    assign wb_data_o    = w_wb_data;
    assign count_o      = r_count;
    assign busy_o       = (r_count != '0);
    assign err_o        = r_err;

endmodule

// File: tb/tb_lsu_multi_outstanding.sv
// Directed testbench for lsu_multi_outstanding. Two instances share all
// stimulus: u_dut with zero-extended byte loads, u_dut_s with sign extension.
module tb_lsu_multi_outstanding;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i, req_wen_i, req_byte_i, flush_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        mem_yumi_i, mem_rvalid_i, wb_ready_i;
    logic [31:0] mem_rdata_i;

    logic        req_ready_o, mem_valid_o, mem_wen_o, mem_byte_o, mem_yumi_o;
    logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o;
    logic        wb_valid_o, wb_is_load_o, busy_o, err_o;
    logic [4:0]  wb_rd_o;
    logic [2:0]  count_o;

    logic        s_req_ready, s_mem_valid, s_mem_wen, s_mem_byte, s_mem_yumi;
    logic [31:0] s_mem_addr, s_mem_wdata, s_wb_data;
    logic        s_wb_valid, s_wb_is_load, s_busy, s_err;
    logic [4:0]  s_wb_rd;
    logic [2:0]  s_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu_multi_outstanding #(.BYTE_SEXT(0)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wen_i(req_wen_i),
        .req_byte_i(req_byte_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_rd_i(req_rd_i), .flush_i(flush_i),
        .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_byte_o(mem_byte_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_yumi_i(mem_yumi_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_yumi_o(mem_yumi_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_is_load_o(wb_is_load_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .count_o(count_o), .busy_o(busy_o), .err_o(err_o)
    );

    lsu_multi_outstanding #(.BYTE_SEXT(1)) u_dut_s (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(s_req_ready), .req_wen_i(req_wen_i),
        .req_byte_i(req_byte_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_rd_i(req_rd_i), .flush_i(flush_i),
        .mem_valid_o(s_mem_valid), .mem_wen_o(s_mem_wen), .mem_byte_o(s_mem_byte),
        .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata), .mem_yumi_i(mem_yumi_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_yumi_o(s_mem_yumi),
        .wb_valid_o(s_wb_valid), .wb_ready_i(wb_ready_i), .wb_is_load_o(s_wb_is_load),
        .wb_rd_o(s_wb_rd), .wb_data_o(s_wb_data),
        .count_o(s_count), .busy_o(s_busy), .err_o(s_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i  = 1'b0;
        req_wen_i    = 1'b0;
        req_byte_i   = 1'b0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        req_rd_i     = '0;
        flush_i      = 1'b0;
        mem_yumi_i   = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        wb_ready_i   = 1'b1;
    endtask

    // Accept one request, then issue it with mem_yumi_i in the following cycle
    task automatic push(input logic wen, input logic byt, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
        req_valid_i = 1'b1;
        req_wen_i   = wen;
        req_byte_i  = byt;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_rd_i    = rd;
        #1;
        check("push_ready", 64'(req_ready_o), 64'(1));
        step();
        req_valid_i = 1'b0;
        mem_yumi_i  = 1'b1;
        #1;
        check("push_mem_valid", 64'(mem_valid_o), 64'(1));
        check("push_mem_addr", 64'(mem_addr_o), 64'(addr));
        step();
        mem_yumi_i = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_count", 64'(count_o), 64'(0));
        check("rst_ready", 64'(req_ready_o), 64'(1));
        check("rst_mem_valid", 64'(mem_valid_o), 64'(0));
        check("rst_mem_yumi", 64'(mem_yumi_o), 64'(0));
        check("rst_wb_valid", 64'(wb_valid_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        step();

        // Four loads rd=1..4, in-order responses 10..40
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 1'b0, 32'h1000 + 32'(4 * i), 32'h0, 5'(i + 1));
        end
        #1;
        check("full_count", 64'(count_o), 64'(4));
        check("full_ready", 64'(req_ready_o), 64'(0));
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        #1;
        check("full_no_accept", 64'(count_o), 64'(4));
        for (int i = 0; i < 4; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'(10 * (i + 1));
            #1;
            check("ret_valid", 64'(wb_valid_o), 64'(1));
            check("ret_rd", 64'(wb_rd_o), 64'(i + 1));
            check("ret_data", 64'(wb_data_o), 64'(10 * (i + 1)));
            check("ret_yumi", 64'(mem_yumi_o), 64'(1));
            check("ret_count", 64'(count_o), 64'(4 - i));
            step();
        end
        mem_rvalid_i = 1'b0;
        #1;
        check("drain_count", 64'(count_o), 64'(0));
        check("drain_busy", 64'(busy_o), 64'(0));

        // Byte load 0xF3: zero- vs sign-extended
        push(1'b0, 1'b1, 32'h2003, 32'h0, 5'd7);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_00F3;
        #1;
        check("byte_zext", 64'(wb_data_o), 64'h0000_00F3);
        check("byte_sext", 64'(s_wb_data), 64'hFFFF_FFF3);
        check("byte_rd", 64'(wb_rd_o), 64'(7));
        step();
        mem_rvalid_i = 1'b0;

        // Stalled store held stable, flushed in its third cycle
        req_valid_i = 1'b1;
        req_wen_i   = 1'b1;
        req_addr_i  = 32'h200;
        req_wdata_i = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) begin
                flush_i     = 1'b1;
                req_valid_i = 1'b1;
            end
            #1;
            if (c <= 3) begin
                check("st_valid", 64'(mem_valid_o), 64'(1));
                check("st_addr", 64'(mem_addr_o), 64'h200);
                check("st_wdata", 64'(mem_wdata_o), 64'hDEAD_BEEF);
                check("st_wen", 64'(mem_wen_o), 64'(1));
                check("st_count", 64'(count_o), 64'(1));
            end else begin
                check("fl_valid", 64'(mem_valid_o), 64'(0));
                check("fl_count", 64'(count_o), 64'(0));
                check("fl_wb", 64'(wb_valid_o), 64'(0));
            end
            if (c == 3) check("fl_ready", 64'(req_ready_o), 64'(0));
            step();
            flush_i     = 1'b0;
            req_valid_i = 1'b0;
        end

        // Flush together with yumi: issue wins, store later retires with data 0
        req_valid_i = 1'b1;
        req_wen_i   = 1'b1;
        req_addr_i  = 32'h300;
        step();
        idle_inputs();
        flush_i    = 1'b1;
        mem_yumi_i = 1'b1;
        step();
        idle_inputs();
        #1;
        check("fy_count", 64'(count_o), 64'(1));
        check("fy_valid", 64'(mem_valid_o), 64'(0));
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h55;
        #1;
        check("st_ret_valid", 64'(wb_valid_o), 64'(1));
        check("st_ret_isload", 64'(wb_is_load_o), 64'(0));
        check("st_ret_data", 64'(wb_data_o), 64'(0));
        step();
        mem_rvalid_i = 1'b0;
        #1;
        check("st_ret_count", 64'(count_o), 64'(0));

        // Flush of pending rd=10 while issued rd=9 retires: count drops by 2
        push(1'b0, 1'b0, 32'h400, 32'h0, 5'd9);
        req_valid_i = 1'b1;
        req_addr_i  = 32'h404;
        req_rd_i    = 5'd10;
        step();
        idle_inputs();
        flush_i      = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h99;
        #1;
        check("fr_count_pre", 64'(count_o), 64'(2));
        check("fr_wb_rd", 64'(wb_rd_o), 64'(9));
        check("fr_wb_data", 64'(wb_data_o), 64'h99);
        step();
        idle_inputs();
        #1;
        check("fr_count", 64'(count_o), 64'(0));
        check("fr_mem_valid", 64'(mem_valid_o), 64'(0));
        check("fr_err", 64'(err_o), 64'(0));

        // Writeback stall holds the response
        push(1'b0, 1'b0, 32'h500, 32'h0, 5'd12);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234;
        wb_ready_i   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_yumi", 64'(mem_yumi_o), 64'(0));
            check("stall_wb_valid", 64'(wb_valid_o), 64'(1));
            check("stall_count", 64'(count_o), 64'(1));
            step();
        end
        wb_ready_i = 1'b1;
        #1;
        check("stall_release_yumi", 64'(mem_yumi_o), 64'(1));
        check("stall_release_rd", 64'(wb_rd_o), 64'(12));
        step();
        mem_rvalid_i = 1'b0;
        #1;
        check("stall_count_after", 64'(count_o), 64'(0));

        // Response with nothing tracked is dropped and sets sticky error
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD;
        #1;
        check("orph_yumi", 64'(mem_yumi_o), 64'(1));
        check("orph_wb_valid", 64'(wb_valid_o), 64'(0));
        step();
        mem_rvalid_i = 1'b0;
        #1;
        check("orph_err", 64'(err_o), 64'(1));
        repeat (3) step();
        check("orph_err_sticky", 64'(err_o), 64'(1));

        // Reset with three outstanding, then a stale response
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 1'b0, 32'h600 + 32'(4 * i), 32'h0, 5'(i + 20));
        end
        #1;
        check("mid_count", 64'(count_o), 64'(3));
        reset = 1'b1;
        step();
        check("mid_rst_count", 64'(count_o), 64'(0));
        check("mid_rst_ready", 64'(req_ready_o), 64'(1));
        check("mid_rst_mem_valid", 64'(mem_valid_o), 64'(0));
        check("mid_rst_err", 64'(err_o), 64'(0));
        reset = 1'b0;
        step();
        mem_rvalid_i = 1'b1;
        #1;
        check("stale_yumi", 64'(mem_yumi_o), 64'(1));
        check("stale_wb_valid", 64'(wb_valid_o), 64'(0));
        step();
        mem_rvalid_i = 1'b0;
        #1;
        check("stale_err", 64'(err_o), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
